// File: rtl/mmu_refill.sv
// mmu_refill: hardware refill engine for the mmu register interface.
// On a translation miss it reads the mmu fault register, fetches the matching
// PTE from an in-memory page table, writes the mapping into the mmu and then
// clears the fault. All outputs are registered.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start               one-cycle refill request (honoured only when idle)
//   busy/done/fail      status; done and fail are one-cycle pulses
//   fail_cause          1=protection fault, 2=invalid PTE, 3=memory timeout
//   cfg_write/cfg_data  load page-table base (bit 0 forced to 0)
//   reg_read            mmu fault register (combinational from the mmu)
//   reg_write/reg_data  mmu register write port
//   mem_req/mem_addr    page-table read request
//   mem_ack/mem_rdata   page-table read completion and PTE
module mmu_refill #(
   parameter int RV      = 16,
   parameter int PA      = RV,
   parameter int VA      = RV,
   parameter int NMMU    = 8,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [1:0]    fail_cause,
   input  logic          cfg_write,
   input  logic [PA-1:0] cfg_data,
   input  logic [RV-1:0] reg_read,
   output logic          reg_write,
   output logic [RV-1:0] reg_data,
   output logic          mem_req,
   output logic [PA-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [RV-1:0] mem_rdata
);

   localparam int PW = $clog2(NMMU);
   localparam int IW = PW + 2;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_FETCH   = 3'd2,
      ST_MAP     = 3'd3,
      ST_CLEAR   = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t        state_r, state_nxt_s;
   logic [PA-1:0] ptbase_r;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic [PW-1:0] page_r, page_nxt_s;
   logic          ins_r, ins_nxt_s;
   logic          sup_r, sup_nxt_s;
   logic          done_nxt_s, fail_nxt_s, reg_write_nxt_s, mem_req_nxt_s;
   logic [1:0]    cause_nxt_s;
   logic [RV-1:0] reg_data_nxt_s, clear_data_s;
   logic [PA-1:0] mem_addr_nxt_s;
   logic [IW-1:0] idx_s;
   logic          unused_s;

   // Mapping-slot index taken straight from the fault register during CAPTURE.
   assign idx_s = {reg_read[4], reg_read[3], reg_read[RV-1:RV-PW]};

   // Fault-register fields that the engine never looks at.
   assign unused_s = ^{reg_read[RV-PW-1:5], reg_read[2], reg_read[0],
                       mem_rdata[0], cfg_data[0], 1'(VA)};

   // Fault-register write: keep page/ins/sup, clear write/valid, bit 0 = 0.
   always_comb begin
      clear_data_s             = {RV{1'b0}};
      clear_data_s[RV-1:RV-PW] = page_r;
      clear_data_s[4]          = ins_r;
      clear_data_s[3]          = sup_r;
   end

   // Page-table base register, writable in any state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptbase_r <= {PA{1'b0}};
      end else if (cfg_write) begin
         ptbase_r <= {cfg_data[PA-1:1], 1'b0};
      end else begin
         ptbase_r <= ptbase_r;
      end
   end

   // Next-state and next-output logic; outputs are registered one step later
   // so each output is valid in the same cycle as the state it belongs to.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      page_nxt_s      = page_r;
      ins_nxt_s       = ins_r;
      sup_nxt_s       = sup_r;
      done_nxt_s      = 1'b0;
      fail_nxt_s      = 1'b0;
      reg_write_nxt_s = 1'b0;
      mem_req_nxt_s   = 1'b0;
      cause_nxt_s     = fail_cause;
      reg_data_nxt_s  = reg_data;
      mem_addr_nxt_s  = mem_addr;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_CAPTURE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            page_nxt_s = reg_read[RV-1:RV-PW];
            ins_nxt_s  = reg_read[4];
            sup_nxt_s  = reg_read[3];
            if (reg_read[1]) begin
               fail_nxt_s  = 1'b1;
               cause_nxt_s = 2'd1;
               state_nxt_s = ST_IDLE;
            end else begin
               // PTEs are 2 bytes wide; the sum wraps modulo 2^PA.
               mem_addr_nxt_s = ptbase_r + (PA'(idx_s) << 1'b1);
               mem_req_nxt_s  = 1'b1;
               cnt_nxt_s      = {CW{1'b0}};
               state_nxt_s    = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // An ack on the final counted cycle still wins over the timeout.
            if (mem_ack) begin
               if (mem_rdata[1]) begin
                  reg_write_nxt_s = 1'b1;
                  reg_data_nxt_s  = {mem_rdata[RV-1:3], mem_rdata[2], 2'b11};
                  state_nxt_s     = ST_MAP;
               end else begin
                  fail_nxt_s  = 1'b1;
                  cause_nxt_s = 2'd2;
                  state_nxt_s = ST_IDLE;
               end
            end else if (cnt_r == CNT_LAST) begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
               fail_nxt_s  = 1'b1;
               cause_nxt_s = 2'd3;
               state_nxt_s = ST_IDLE;
            end else begin
               cnt_nxt_s     = cnt_r + CNT_ONE;
               mem_req_nxt_s = 1'b1;
            end
         end
         ST_MAP: begin
            // Mapping must land before the fault clear: the mmu picks the
            // slot from the fault-register fields still in place.
            reg_write_nxt_s = 1'b1;
            reg_data_nxt_s  = clear_data_s;
            state_nxt_s     = ST_CLEAR;
         end
         ST_CLEAR: begin
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_DONE;
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r      <= {CW{1'b0}};
         page_r     <= {PW{1'b0}};
         ins_r      <= 1'b0;
         sup_r      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         fail_cause <= 2'd0;
         reg_write  <= 1'b0;
         reg_data   <= {RV{1'b0}};
         mem_req    <= 1'b0;
         mem_addr   <= {PA{1'b0}};
      end else begin
         cnt_r      <= cnt_nxt_s;
         page_r     <= page_nxt_s;
         ins_r      <= ins_nxt_s;
         sup_r      <= sup_nxt_s;
         busy       <= (state_nxt_s != ST_IDLE);
         done       <= done_nxt_s;
         fail       <= fail_nxt_s;
         fail_cause <= cause_nxt_s;
         reg_write  <= reg_write_nxt_s;
         reg_data   <= reg_data_nxt_s;
         mem_req    <= mem_req_nxt_s;
         mem_addr   <= mem_addr_nxt_s;
      end
   end

endmodule

// File: doc/mmu_refill.md
Name: mmu_refill

Overview:
- Hardware refill engine for the mmu register interface; acts as the initiator on that interface.
- On a translation miss it:
  - reads the fault register;
  - fetches the matching entry from an in-memory page table;
  - writes the mapping into the mmu;
  - clears the fault.
- Sits beside the mmu and shares its register port with the CPU.
- While busy, the core holds the faulting access.

Parameters:
- RV, 16: register/data width.
- PA, RV: physical address width.
- VA, RV: virtual address width.
- NMMU, 8: mappings per bank. Index width IW = $clog2(NMMU)+2; page-bit width PW = $clog2(NMMU).
- TIMEOUT, 15: maximum cycles to wait for mem_ack.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse requesting a refill. Ignored unless state is IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: refill succeeded.
- fail  out  1  one-cycle pulse: refill aborted.
- fail_cause  out  2  cause for the last fail. Held until the next fail. 1=protection fault, 2=invalid PTE, 3=memory timeout.
- cfg_write  in  1  load page-table base.
- cfg_data  in  PA  new base. Bit 0 is ignored and forced 0.
- reg_read  in  RV  mmu fault register, combinational.
  - [RV-1:RV-PW] fault page.
  - 4 ins, 3 sup, 2 write, 1 valid (1 = protection fault, not a miss).
- reg_write  out  1  mmu register write strobe.
- reg_data  out  RV  mmu register write data.
- mem_req  out  1  page-table read request.
- mem_addr  out  PA  byte address of the PTE.
- mem_ack  in  1  read completion.
- mem_rdata  in  RV  PTE, valid when mem_ack=1.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; ptbase=0.
  - busy, done, fail, reg_write, mem_req = 0.
  - fail_cause=0; reg_data=0; mem_addr=0; timeout counter=0.
- Reset mid-operation aborts immediately. No reg_write is issued after reset is released.
- cfg_write is accepted in any state. It takes effect for the next FETCH entry; an in-flight fetch keeps its latched address.
- States and transitions:
  - IDLE: on start go to CAPTURE (busy=1 from the next cycle).
  - CAPTURE (1 cycle): latch fault page, ins, sup and valid from reg_read.
    - Index idx = {ins, sup, page}.
    - If valid=1: pulse fail with cause=1, go to IDLE.
    - Else: mem_addr = ptbase + (idx<<1), modulo 2^PA (wraps); go to FETCH.
  - FETCH: mem_req=1, with mem_addr held stable until mem_ack is sampled high. The counter increments each cycle without ack.
    - Ack (ack in the same cycle the counter reaches TIMEOUT: ack wins): latch mem_rdata as pte, drop mem_req.
      - If pte[1]=0: fail with cause=2, go to IDLE.
      - Else go to MAP.
    - Counter reaches TIMEOUT with no ack: drop mem_req, fail with cause=3, go to IDLE.
  - MAP (1 cycle): reg_write=1, reg_data = {pte[RV-1:3], pte[2], 1'b1, 1'b1}.
    - Upper phys bits come from the PTE; bit 2 writeable; bit 1 valid; bit 0 = 1 selects the mapping write.
  - CLEAR (1 cycle): reg_write=1, reg_data = {page, zeros, ins, sup, 1'b0, 1'b0, 1'b0}.
    - This preserves the index fields, clears the write and valid bits, and has bit 0 = 0 (fault-register write).
  - DONE (1 cycle): done=1, then IDLE.
- Ordering: MAP must precede CLEAR, because the mmu selects the mapping slot from the fault-register fields.
- reg_write is asserted only in MAP and CLEAR.
- Latency: start at cycle 0 → CAPTURE at 1 → mem_req from 2 → ack at cycle A → MAP at A+1 → CLEAR at A+2 → done at A+3.
- start while busy: ignored, not queued.
- done and fail are mutually exclusive and never both asserted.

Test Plan:
- Basic refill:
  - Setup: ptbase=0x1000; reg_read=0x6000 (page 3, user, data, miss); PTE 0xA006 returned with ack at cycle 4.
  - Required: mem_addr=0x1006; MAP reg_data=0xA007 at cycle 5; CLEAR reg_data=0x6000 at cycle 6; done at cycle 7.
- Instruction miss:
  - Setup: reg_read=0xE018 (page 7, ins, sup).
  - Required: idx=31, mem_addr=ptbase+0x3E; CLEAR reg_data=0xE018.
- Protection fault:
  - Setup: reg_read bit 1=1.
  - Required: fail with cause=1 one cycle after CAPTURE; mem_req and reg_write never asserted.
- Invalid PTE:
  - Setup: PTE 0x4000.
  - Required: fail with cause=2; no reg_write.
- Timeout:
  - mem_ack held low: fail with cause=3 after TIMEOUT cycles in FETCH; mem_req drops the same cycle.
  - Ack on the timeout cycle: refill succeeds.
- Base wrap and reset:
  - ptbase=0xFFF0, idx=31 → mem_addr=0x002E.
  - reset asserted during FETCH: all outputs 0 immediately; start after release restarts cleanly.
  - start during busy is ignored.
